// File: rtl/jk_seq_pkg.sv
// Shared types and constants for the JK bank sequencer: command opcodes,
// FSM states, and the {J,K} drive encoding of the team's JK cell.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_INC   = 2'd2,
    OP_DEC   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // {J,K} drive codes; note this cell toggles on 00 and holds on 11
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_HOLD = 2'b11;
  localparam logic [1:0] JK_TOG  = 2'b00;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop using the team cell encoding (00 toggles, 11 holds),
// asynchronously reset to Q=0.
module jk_cell
  import jk_seq_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK next-state per the cell encoding
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_SET:  q <= 1'b1;
        JK_CLR:  q <= 1'b0;
        JK_HOLD: q <= q;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer owning a bank of WIDTH JK cells. Handles CLEAR,
// LOAD and multi-step INC/DEC over a valid/ready port.
// Optional macro JK_SEQ_SATURATE_EN: INC at all-ones / DEC at zero holds
// instead of wrapping (wrap still pulses for each suppressed step).
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e                  state_q;
  op_e                     op_q;
  logic [WIDTH-1:0]        data_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [WIDTH-1:0][1:0]   jk_drive;
  logic [WIDTH-1:0]        tog_inc;
  logic [WIDTH-1:0]        tog_dec;
  logic                    stepping;
  logic                    at_limit;
  logic                    sat_hold;

  // A real count step happens only for INC/DEC with steps remaining
  always_comb begin
    stepping = (state_q == ST_EXEC) && ((op_q == OP_INC) || (op_q == OP_DEC))
               && (cnt_q != '0);
    at_limit = (op_q == OP_INC) ? (&value) : ~(|value);
    wrap     = stepping & at_limit;
  end

`ifdef JK_SEQ_SATURATE_EN
  assign sat_hold = wrap;
`else
  assign sat_hold = 1'b0;
`endif

  // Per-bit J/K mask: ripple carry/borrow prefixes pick the toggling bits
  always_comb begin
    tog_inc    = '0;
    tog_dec    = '0;
    tog_inc[0] = 1'b1;
    tog_dec[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tog_inc[i] = tog_inc[i-1] & value[i-1];
      tog_dec[i] = tog_dec[i-1] & ~value[i-1];
    end
    for (int i = 0; i < WIDTH; i++) begin
      jk_drive[i] = JK_HOLD;
      if (state_q == ST_EXEC) begin
        case (op_q)
          OP_CLEAR: jk_drive[i] = JK_CLR;
          OP_LOAD:  jk_drive[i] = data_q[i] ? JK_SET : JK_CLR;
          OP_INC:   if (stepping && !sat_hold && tog_inc[i]) jk_drive[i] = JK_TOG;
          default:  if (stepping && !sat_hold && tog_dec[i]) jk_drive[i] = JK_TOG;
        endcase
      end
    end
  end

  // Command FSM with step counter and registered handshake/status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_CLEAR;
      data_q    <= '0;
      cnt_q     <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q      <= op_e'(cmd_op);
            data_q    <= cmd_data;
            cnt_q     <= cmd_count;
            state_q   <= ST_EXEC;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (stepping) cnt_q <= cnt_q - CNT_W'(1);
          if (!stepping || (cnt_q == CNT_W'(1))) begin
            state_q <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state_q   <= ST_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // The JK register bank
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clock (clock),
      .reset (reset),
      .j     (jk_drive[g][1]),
      .k     (jk_drive[g][0]),
      .q     (value[g])
    );
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer: per-step expectations come from a
// small reference counter model and are queued at drive time, then popped
// as each EXEC cycle completes.
module tb_jk_bank_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic             wrap;

  typedef struct {
    logic [WIDTH-1:0] v;
    logic             w;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] mdl;
  int               errors = 0;
  int               checks = 0;
  int               seen_done;

  jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: queue one {value-after, wrap} entry per EXEC cycle
  task automatic model(input logic [1:0] op, input logic [WIDTH-1:0] data, input int cnt);
    exp_t e;
    case (op)
      2'd0: begin mdl = '0;   e.v = mdl; e.w = 1'b0; exp_q.push_back(e); end
      2'd1: begin mdl = data; e.v = mdl; e.w = 1'b0; exp_q.push_back(e); end
      default: begin
        if (cnt == 0) begin
          e.v = mdl; e.w = 1'b0; exp_q.push_back(e);
        end else begin
          for (int s = 0; s < cnt; s++) begin
            if (op == 2'd2) begin
              e.w = (mdl == 4'hF);
`ifdef JK_SEQ_SATURATE_EN
              if (!e.w) mdl = mdl + 4'd1;
`else
              mdl = mdl + 4'd1;
`endif
            end else begin
              e.w = (mdl == 4'h0);
`ifdef JK_SEQ_SATURATE_EN
              if (!e.w) mdl = mdl - 4'd1;
`else
              mdl = mdl - 4'd1;
`endif
            end
            e.v = mdl;
            exp_q.push_back(e);
          end
        end
      end
    endcase
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the next IDLE cycle.
  // hold_clear keeps cmd_valid high with a CLEAR op throughout the command.
  task automatic run_cmd(input string tag, input logic [1:0] op,
                         input logic [WIDTH-1:0] data, input int cnt, input bit hold_clear);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = CNT_W'(cnt);
    chk({tag, ".ready"}, cmd_ready, 1);
    model(op, data, cnt);
    @(posedge clock);
    @(negedge clock);
    if (hold_clear) begin
      cmd_op   = 2'd0;
      cmd_data = ~data;
    end else begin
      cmd_valid = 1'b0;
      cmd_op    = ~op;
      cmd_data  = ~data;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".nready"}, cmd_ready, 0);
      chk({tag, ".wrap"}, wrap, e.w);
      chk({tag, ".ndone"}, done, 0);
      @(negedge clock);
      chk({tag, ".value"}, value, e.v);
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".dbusy"}, busy, 1);
    @(negedge clock);
    chk({tag, ".done_off"}, done, 0);
    chk({tag, ".idle_ready"}, cmd_ready, 1);
    chk({tag, ".idle_busy"}, busy, 0);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = '0;
    cmd_count = '0;
    mdl       = '0;
    repeat (2) @(negedge clock);
    chk("rst.value", value, 0);
    chk("rst.ready", cmd_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.wrap", wrap, 0);
    reset = 1'b0;
    @(negedge clock);

    run_cmd("load_a", 2'd1, 4'hA, 0, 1'b0);
    run_cmd("load_e", 2'd1, 4'hE, 0, 1'b0);
    run_cmd("inc3",   2'd2, 4'h0, 3, 1'b0);
    run_cmd("clear",  2'd0, 4'h7, 0, 1'b0);
    run_cmd("dec2",   2'd3, 4'h0, 2, 1'b0);
    run_cmd("load_5", 2'd1, 4'h5, 0, 1'b0);
    run_cmd("inc0",   2'd2, 4'h0, 0, 1'b0);
    run_cmd("dec5",   2'd3, 4'h0, 5, 1'b0);
    run_cmd("busy_ld", 2'd1, 4'h9, 0, 1'b1);
    run_cmd("clr_acc", 2'd0, 4'h0, 0, 1'b0);

    // Reset in the third EXEC cycle of a 10-step INC
    run_cmd("load_3", 2'd1, 4'h3, 0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_count = CNT_W'(10);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort.pre_value", value, 4'h5);
    reset = 1'b1;
    #1;
    chk("abort.value", value, 0);
    chk("abort.ready", cmd_ready, 1);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.wrap", wrap, 0);
    @(negedge clock);
    reset = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      if (done || wrap || busy) seen_done++;
    end
    chk("abort.quiet", seen_done, 0);
    chk("abort.hold", value, 0);
    mdl = '0;
    run_cmd("post_ld", 2'd1, 4'hC, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Command-driven sequencer that owns a bank of WIDTH JK flip-flop cells and computes their per-bit J/K drive every cycle. It implements load, clear, and multi-step increment/decrement operations over a valid/ready command port. The block sits between a host control FSM and the JK register bank, so no other logic drives J/K directly.

## Interface
- WIDTH, 4: number of JK cells in the bank (2..16).
- CNT_W, 8: width of the step-count field.
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (IDLE only).
- cmd_op  in  2  0=CLEAR, 1=LOAD, 2=INC, 3=DEC.
- cmd_data  in  WIDTH  load value (LOAD only).
- cmd_count  in  CNT_W  number of INC/DEC steps.
- value  out  WIDTH  Q outputs of the JK bank.
- busy  out  1  high in EXEC and DONE.
- done  out  1  one-cycle pulse when a command completes.
- wrap  out  1  one-cycle pulse on an INC from all-ones or a DEC from zero.

## Operation
- Cell JK encoding, fixed for the team's cell: J=1,K=0 sets; J=0,K=1 clears; J=1,K=1 holds; J=0,K=0 toggles.
- Idle drive: all bits hold (J=K=1).
- FSM states: IDLE, EXEC, DONE.
- IDLE: cmd_ready=1. When cmd_valid & cmd_ready, capture op, data and count, then go to EXEC. cmd_ready is 0 in all other states.
- EXEC, CLEAR: all bits are cleared in one cycle, then go to DONE.
- EXEC, LOAD: bit i is set if cmd_data[i] is 1, otherwise cleared; one cycle, then go to DONE.
- EXEC, INC: each cycle performs one step. Bit i toggles when all lower bits are 1; other bits hold. The step counter decrements, and the FSM goes to DONE after the last step.
- EXEC, DEC: same as INC, but bit i toggles when all lower bits are 0.
- cmd_count=0 for INC/DEC: zero steps; EXEC lasts one cycle with all bits holding, then go to DONE.
- wrap is asserted in the same cycle as the wrapping step; the value wraps modulo 2^WIDTH.
- DONE: done=1 for one cycle, then return to IDLE.
- cmd_op and cmd_data changing after acceptance have no effect.

## Timing
- Reset values: value=0, cmd_ready=1, busy=0, done=0, wrap=0, state=IDLE, step counter=0.
- Handshake accepted at edge T. EXEC occupies cycles T+1..T+n, where n=1 for CLEAR, LOAD and count 0, and n=cmd_count otherwise. done is high during cycle T+n+1. cmd_ready rises at T+n+2.
- value updates at the edge ending each EXEC cycle.
- Back-to-back throughput: n+2 cycles per command.
- cmd_valid while busy: the command is ignored and not stalled; the host must hold cmd_valid until it sees cmd_ready.
- Reset asserted mid-EXEC: the command is aborted, value becomes 0 immediately, and neither done nor wrap is emitted.

## Configuration
- JK_SEQ_SATURATE_EN defined: an INC step at all-ones or a DEC step at zero holds all bits instead of toggling. wrap still pulses for each suppressed step, and the remaining steps continue counting down.
- JK_SEQ_SATURATE_EN undefined: modulo wrap-around as described in Operation.

## Structure
- Package jk_seq_pkg contains:
  - op enum (CLEAR/LOAD/INC/DEC);
  - FSM state enum;
  - JK drive constants (SET, CLR, HOLD, TOG as 2-bit {J,K}).
- Sub-module jk_cell: a single JK flip-flop with the encoding above, using async reset to Q=0. It is instantiated WIDTH times by a generate loop.
- The top level contains only the FSM, the step counter and the J/K mask logic.

## Test plan
- Reset, then LOAD data=4'b1010: value=4'hA at T+1, done pulse at T+2, cmd_ready=1 at T+3.
- INC with count=3 from 4'hE: values E→F→0→1, wrap pulses exactly on the F→0 step, done after 3 EXEC cycles.
- DEC with count=2 from 0 and JK_SEQ_SATURATE_EN defined: value stays 0, wrap pulses twice, done pulses once.
- INC with count=0 from 4'h5: value stays 5, EXEC lasts one cycle, done pulses.
- Assert reset during cycle 3 of INC with count=10: value=0 immediately, state IDLE, no done.
- Drive cmd_valid with CLEAR while busy in a LOAD command: CLEAR is ignored until cmd_ready, then accepted, and value=0.
